// File: rtl/instr_decoder.sv
// MIPS32 instruction decoder: one combinational flag per supported instruction,
// plus a sticky reserved-instruction status bit that is the only clocked state.
module instr_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    output logic        lb,
    output logic        lbu,
    output logic        lh,
    output logic        lhu,
    output logic        lw,
    output logic        sb,
    output logic        sh,
    output logic        sw,
    output logic        swl,
    output logic        swr,
    output logic        add,
    output logic        addu,
    output logic        sub,
    output logic        subu,
    output logic        mult,
    output logic        multu,
    output logic        div,
    output logic        divu,
    output logic        sll,
    output logic        srl,
    output logic        sra,
    output logic        sllv,
    output logic        srlv,
    output logic        srav,
    output logic        _and,
    output logic        _or,
    output logic        _xor,
    output logic        _nor,
    output logic        addi,
    output logic        addiu,
    output logic        andi,
    output logic        ori,
    output logic        xori,
    output logic        lui,
    output logic        slt,
    output logic        slti,
    output logic        sltiu,
    output logic        sltu,
    output logic        beq,
    output logic        bne,
    output logic        blez,
    output logic        bgtz,
    output logic        bltz,
    output logic        bgez,
    output logic        j,
    output logic        jal,
    output logic        jalr,
    output logic        jr,
    output logic        mfhi,
    output logic        mflo,
    output logic        mthi,
    output logic        mtlo,
    output logic        madd,
    output logic        maddu,
    output logic        msub,
    output logic        msubu,
    output logic        movn,
    output logic        movz,
    output logic        mfc0,
    output logic        mtc0,
    output logic        eret,
    output logic        ri,
    output logic        ri_seen
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       special;
    logic       regimm;
    logic       special2;
    logic       cop0;
    logic       ri_seen_q;
    logic       ri_seen_d;

    assign op    = IR[31:26];
    assign rs    = IR[25:21];
    assign rt    = IR[20:16];
    assign funct = IR[5:0];

    assign special  = (op == 6'b000000);
    assign regimm   = (op == 6'b000001);
    assign special2 = (op == 6'b011100);
    assign cop0     = (op == 6'b010000);

    assign lb    = (op == 6'b100000);
    assign lh    = (op == 6'b100001);
    assign lw    = (op == 6'b100011);
    assign lbu   = (op == 6'b100100);
    assign lhu   = (op == 6'b100101);
    assign sb    = (op == 6'b101000);
    assign sh    = (op == 6'b101001);
    assign swl   = (op == 6'b101010);
    assign sw    = (op == 6'b101011);
    assign swr   = (op == 6'b101110);

    assign add   = special && (funct == 6'b100000);
    assign addu  = special && (funct == 6'b100001);
    assign sub   = special && (funct == 6'b100010);
    assign subu  = special && (funct == 6'b100011);
    assign _and  = special && (funct == 6'b100100);
    assign _or   = special && (funct == 6'b100101);
    assign _xor  = special && (funct == 6'b100110);
    assign _nor  = special && (funct == 6'b100111);
    assign slt   = special && (funct == 6'b101010);
    assign sltu  = special && (funct == 6'b101011);
    assign mult  = special && (funct == 6'b011000);
    assign multu = special && (funct == 6'b011001);
    assign div   = special && (funct == 6'b011010);
    assign divu  = special && (funct == 6'b011011);
    // shamt/rd are ignored, so IR=0 (nop) lands on sll.
    assign sll   = special && (funct == 6'b000000);
    assign srl   = special && (funct == 6'b000010);
    assign sra   = special && (funct == 6'b000011);
    assign sllv  = special && (funct == 6'b000100);
    assign srlv  = special && (funct == 6'b000110);
    assign srav  = special && (funct == 6'b000111);
    assign jr    = special && (funct == 6'b001000);
    assign jalr  = special && (funct == 6'b001001);
    assign movz  = special && (funct == 6'b001010);
    assign movn  = special && (funct == 6'b001011);
    assign mfhi  = special && (funct == 6'b010000);
    assign mthi  = special && (funct == 6'b010001);
    assign mflo  = special && (funct == 6'b010010);
    assign mtlo  = special && (funct == 6'b010011);

    assign bltz  = regimm && (rt == 5'b00000);
    assign bgez  = regimm && (rt == 5'b00001);

    assign madd  = special2 && (funct == 6'b000000);
    assign maddu = special2 && (funct == 6'b000001);
    assign msub  = special2 && (funct == 6'b000100);
    assign msubu = special2 && (funct == 6'b000101);

    assign mfc0  = cop0 && (rs == 5'b00000);
    assign mtc0  = cop0 && (rs == 5'b00100);
    assign eret  = (IR == 32'h4200_0018);

    assign j     = (op == 6'b000010);
    assign jal   = (op == 6'b000011);
    assign beq   = (op == 6'b000100);
    assign bne   = (op == 6'b000101);
    assign blez  = (op == 6'b000110);
    assign bgtz  = (op == 6'b000111);
    assign addi  = (op == 6'b001000);
    assign addiu = (op == 6'b001001);
    assign slti  = (op == 6'b001010);
    assign sltiu = (op == 6'b001011);
    assign andi  = (op == 6'b001100);
    assign ori   = (op == 6'b001101);
    assign xori  = (op == 6'b001110);
    assign lui   = (op == 6'b001111);

    assign ri = ~|{lb, lbu, lh, lhu, lw, sb, sh, sw, swl, swr,
                   add, addu, sub, subu, mult, multu, div, divu,
                   sll, srl, sra, sllv, srlv, srav, _and, _or, _xor, _nor,
                   addi, addiu, andi, ori, xori, lui, slt, slti, sltiu, sltu,
                   beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                   mfhi, mflo, mthi, mtlo, madd, maddu, msub, msubu,
                   movn, movz, mfc0, mtc0, eret};

    assign ri_seen_d = ri_seen_q | ri;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ri_seen_q <= 1'b0;
        end else begin
            ri_seen_q <= ri_seen_d;
        end
    end

    assign ri_seen = ri_seen_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: hand-decoded instruction words, an exclusivity
// sweep over every opcode/funct pair, and the sticky ri_seen behaviour.
module tb_instr_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] IR;
  logic lb, lbu, lh, lhu, lw, sb, sh, sw, swl, swr;
  logic add, addu, sub, subu, mult, multu, div, divu;
  logic sll, srl, sra, sllv, srlv, srav, _and, _or, _xor, _nor;
  logic addi, addiu, andi, ori, xori, lui, slt, slti, sltiu, sltu;
  logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr;
  logic mfhi, mflo, mthi, mtlo, madd, maddu, msub, msubu;
  logic movn, movz, mfc0, mtc0, eret, ri, ri_seen;

  int n_tests = 0;
  int n_fail  = 0;

  // Flag vector in port order: position 0 (lb) is bit 60, position 60 (eret) is bit 0.
  logic [60:0] flags;
  assign flags = {lb, lbu, lh, lhu, lw, sb, sh, sw, swl, swr,
                  add, addu, sub, subu, mult, multu, div, divu,
                  sll, srl, sra, sllv, srlv, srav, _and, _or, _xor, _nor,
                  addi, addiu, andi, ori, xori, lui, slt, slti, sltiu, sltu,
                  beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                  mfhi, mflo, mthi, mtlo, madd, maddu, msub, msubu,
                  movn, movz, mfc0, mtc0, eret};

  localparam int P_SB = 5, P_SW = 7, P_SWR = 9, P_LW = 4, P_ADDU = 11, P_MULT = 14;
  localparam int P_SLL = 18, P_NOR = 27, P_SLTI = 35, P_LUI = 33, P_BEQ = 38;
  localparam int P_BLTZ = 42, P_BGEZ = 43, P_JAL = 45, P_JR = 47, P_MFLO = 49;
  localparam int P_MADD = 52, P_MSUBU = 55, P_MOVN = 56, P_MFC0 = 58, P_MTC0 = 59;
  localparam int P_ERET = 60, P_NONE = -1;

  instr_decoder dut (
    .clk(clk), .reset(reset), .IR(IR),
    .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw),
    .sb(sb), .sh(sh), .sw(sw), .swl(swl), .swr(swr),
    .add(add), .addu(addu), .sub(sub), .subu(subu),
    .mult(mult), .multu(multu), .div(div), .divu(divu),
    .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
    ._and(_and), ._or(_or), ._xor(_xor), ._nor(_nor),
    .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori), .lui(lui),
    .slt(slt), .slti(slti), .sltiu(sltiu), .sltu(sltu),
    .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
    .j(j), .jal(jal), .jalr(jalr), .jr(jr),
    .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
    .madd(madd), .maddu(maddu), .msub(msub), .msubu(msubu),
    .movn(movn), .movz(movz), .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
    .ri(ri), .ri_seen(ri_seen)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [60:0] onehot(input int pos);
    logic [60:0] v;
    v = '0;
    if (pos >= 0) v[60 - pos] = 1'b1;
    return v;
  endfunction

  // Drive IR away from the clock edge and check the full flag vector plus ri.
  task automatic decode_vec(input string tag, input logic [31:0] word, input int pos);
    @(negedge clk);
    IR = word;
    #1;
    check({tag, "_flags"}, 64'(flags), 64'(onehot(pos)));
    check({tag, "_ri"}, 64'(ri), (pos < 0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int viol;
    reset = 1'b1;
    IR = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ri_seen", 64'(ri_seen), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    decode_vec("nop_sll", 32'h0000_0000, P_SLL);
    decode_vec("sw",      32'hAC01_0004, P_SW);
    decode_vec("lw",      32'h8C01_0004, P_LW);
    decode_vec("addu",    32'h0022_1821, P_ADDU);
    decode_vec("madd",    32'h7022_0000, P_MADD);
    decode_vec("eret",    32'h4200_0018, P_ERET);
    decode_vec("eret_ri", 32'h4200_0019, P_NONE);
    decode_vec("bgez",    32'h0401_0003, P_BGEZ);
    decode_vec("bltz",    32'h0400_0003, P_BLTZ);
    decode_vec("regimm_ri", 32'h0402_0000, P_NONE);
    decode_vec("mtc0",    32'h4080_6000, P_MTC0);
    decode_vec("mfc0",    32'h4001_6000, P_MFC0);
    decode_vec("mfc0_f18", 32'h4000_0018, P_MFC0);
    decode_vec("op3f_ri", 32'hFC00_0000, P_NONE);
    decode_vec("jr",      32'h03E0_0008, P_JR);
    decode_vec("jal",     32'h0C00_0010, P_JAL);
    decode_vec("lui",     32'h3C01_1234, P_LUI);
    decode_vec("mult",    32'h0022_0018, P_MULT);
    decode_vec("msubu",   32'h7022_0005, P_MSUBU);
    decode_vec("movn",    32'h0022_180B, P_MOVN);
    decode_vec("mflo",    32'h0000_1812, P_MFLO);
    decode_vec("beq",     32'h1022_FFFF, P_BEQ);
    decode_vec("nor",     32'h0022_1827, P_NOR);
    decode_vec("sb",      32'hA001_0000, P_SB);
    decode_vec("swr",     32'hB801_0000, P_SWR);
    decode_vec("slti",    32'h2801_0005, P_SLTI);
    decode_vec("spec2_ri", 32'h7000_0002, P_NONE);
    decode_vec("spec_ri", 32'h0000_0001, P_NONE);

    // Exclusivity sweep: rs/rt pairs cover REGIMM rt=0/1 and COP0 rs=0/4.
    for (int op = 0; op < 64; op++) begin
      viol = 0;
      for (int fn = 0; fn < 64; fn++) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          IR = {6'(op), (k == 2) ? 5'd4 : 5'd0, (k == 1) ? 5'd1 : 5'd0, 10'd0, 6'(fn)};
          #1;
          if ($countones(flags) > 1) viol++;
          if (ri !== (flags == '0)) viol++;
        end
      end
      check($sformatf("onehot_op%0d", op), 64'(viol), 64'd0);
    end

    // Sticky ri_seen
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    IR = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("ri_seen_legal", 64'(ri_seen), 64'd0);
    @(negedge clk);
    IR = 32'hFC00_0000;
    #1;
    check("ri_seen_no_edge", 64'(ri_seen), 64'd0);
    @(posedge clk);
    #1;
    check("ri_seen_set", 64'(ri_seen), 64'd1);
    @(negedge clk);
    IR = 32'h8C01_0004;
    repeat (3) @(posedge clk);
    #1;
    check("ri_seen_sticky", 64'(ri_seen), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ri_seen_async_clr", 64'(ri_seen), 64'd0);
    IR = 32'hFC00_0000;
    @(posedge clk);
    #1;
    check("ri_seen_reset_prio", 64'(ri_seen), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ri_seen_reset_set", 64'(ri_seen), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
